led_scan_decoder: RTL
=====================

# led_scan_decoder

Receive-side counterpart to the wall clock's multiplexed LED display output. The block samples the shared segment bus and per-digit enable mask, filters scan transitions, and decodes each digit's glyph back to BCD. It reassembles complete HH-MM-SS frames with blank and error flags. It serves as a bench/board monitor and a loop-back checker for the display path.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive cycles that mask and segments must hold constant before a digit is captured (range 1..255).
- `STABLE_FRAMES`, default 3: consecutive identical committed frames required to raise `stable` (range 1..15).
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `display_led_segments` input 8: segment bus, a = bit 7 … g = bit 1, dp = bit 0, 1 = lit.
- `display_led_enable_mask` input 6: digit enables, bits 5-4 = HH, 3-2 = MM, 1-0 = SS, 1 = enabled.
- `time_bcd` output 24: decoded frame, nibble i = digit position i (bits 23:20 = hours tens).
- `blank_mask` output 6: 1 = position not lit during the last frame.
- `frame_strobe` output 1: one-cycle pulse when a new frame is committed to `time_bcd`/`blank_mask`.
- `glyph_error` output 1: one-cycle pulse coincident with `frame_strobe` when the committed frame contained an error.
- `stable` output 1: high while the last `STABLE_FRAMES` committed frames were identical and error-free.

## Operation
- Input qualifier: register mask and segments (dp bit masked off). Settle counter resets on any change and saturates at `SETTLE_CYCLES`. Capture fires once per dwell, on the cycle the counter reaches `SETTLE_CYCLES`. It re-arms only after the inputs change.
- Mask of 0 is idle: no capture, no error. Two-or-more-hot mask at capture: no digit is stored, and the frame error flag is set.
- Glyph decode (segments[7:1] as abcdefg): 0 = 7E, 1 = 30, 2 = 6D, 3 = 79, 4 = 33, 5 = 5B, 6 = 5F, 7 = 70, 8 = 7F, 9 = 7B.
  - All segments off: the position is marked blank, nibble 0.
  - Any other pattern: nibble F, and the frame error flag is set.
- Frame assembly: a working buffer holds 6 nibbles, a seen[5:0] vector and an error flag.
  - A capture at a position whose seen bit is 0 stores the nibble and sets the bit.
  - A capture at a position already seen commits the frame. Unseen positions are committed as blank, nibble 0. The buffer is then cleared and seeded with the triggering capture.
- Blink handling: positions whose enable never asserts within a frame appear in `blank_mask`. This is the normal adjust-mode blink and is not an error.
- Stability: a frame counter compares each committed {time_bcd, blank_mask} with the previous commit.
  - Identical and error-free: increment, saturating at `STABLE_FRAMES`.
  - Otherwise: load 1 if error-free, 0 if errored.
  - `stable` = (counter == `STABLE_FRAMES`).

## Timing
- Capture latency: inputs are registered once, then `SETTLE_CYCLES` cycles are counted. A dwell of N ≥ `SETTLE_CYCLES` cycles yields exactly one capture. A dwell shorter than `SETTLE_CYCLES` yields none.
- Commit: `time_bcd`, `blank_mask`, `glyph_error` and `stable` update in the cycle after the triggering capture. `frame_strobe` is high that same single cycle.
- Reset values: `time_bcd` = 24'h000000, `blank_mask` = 6'h3F, `frame_strobe` = 0, `glyph_error` = 0, `stable` = 0. The working buffer, seen vector, settle counter and frame counter are cleared.
- Reset mid-frame: the partial frame is discarded and no strobe is produced. The first commit after reset requires a full new frame plus one repeated capture.
- Simultaneous capture-repeat and error: the error is attributed to the new frame, not the one being committed.

## Configuration
- `LED_SCAN_DECODER_ALT_GLYPHS_EN` defined: the following alternate glyphs are also accepted without error:
  - 6 = 1F (top segment off)
  - 7 = 72 (with f)
  - 9 = 73 (bottom segment off)
- Undefined: those patterns decode to F and flag an error.

## Test plan
- Scan 12:34:56, dwell 8 cycles per digit, 4 frames → `time_bcd` = 24'h123456, `blank_mask` = 0. `frame_strobe` at the 1st repeat capture. `stable` = 1 after the 3rd identical commit.
- Same scan with bits 5-4 never enabled → `blank_mask` = 6'b110000, `time_bcd` = 24'h003456, `glyph_error` = 0.
- Position 0 segments = 8'h80 (a only) → nibble 0 = F, `glyph_error` pulse, `stable` drops to 0.
- 2-cycle glitch mask 6'b000100 with `SETTLE_CYCLES` = 4 between legal dwells → no capture, frame unchanged. Mask 6'b000011 dwell → `glyph_error`.
- `reset` asserted for 1 cycle mid-frame → all outputs at reset values next cycle. Next strobe only after a full frame.
- Position 3 segments = 8'hE4 (glyph 72) → nibble 7 with `LED_SCAN_DECODER_ALT_GLYPHS_EN`. Without it: F and `glyph_error`.

Source files
------------

// File: rtl/led_scan_decoder.sv
// ---------------------------------------------------------------------------
// led_scan_decoder
//
// Receive-side monitor for a multiplexed 6-digit LED clock display. Samples
// the shared segment bus and the per-digit enable mask, waits for each scan
// dwell to settle, decodes the lit glyph back to BCD and reassembles complete
// HH-MM-SS frames. A frame is committed when a position that was already
// captured in the current frame is captured again.
//
// Parameters:
//   SETTLE_CYCLES  cycles mask+segments must hold before a capture (1..255)
//   STABLE_FRAMES  identical error-free commits needed for 'stable' (1..15)
//
// Optional feature macro:
//   LED_SCAN_DECODER_ALT_GLYPHS_EN  accept alternate 6/7/9 glyph shapes
//
// Ports:
//   clk                      rising-edge clock
//   reset                    synchronous, active-high
//   display_led_segments     [7:1] = abcdefg, [0] = dp (ignored), 1 = lit
//   display_led_enable_mask  one bit per position, 5 = hours tens
//   time_bcd                 committed frame, nibble i = position i
//   blank_mask               1 = position not lit during the last frame
//   frame_strobe             one-cycle pulse on each commit
//   glyph_error              one-cycle pulse with frame_strobe if frame bad
//   stable                   last STABLE_FRAMES commits identical and clean
// ---------------------------------------------------------------------------
module led_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  display_led_segments,
  input  logic [5:0]  display_led_enable_mask,
  output logic [23:0] time_bcd,
  output logic [5:0]  blank_mask,
  output logic        frame_strobe,
  output logic        glyph_error,
  output logic        stable
);

  localparam logic [7:0] SETTLE_C = 8'(SETTLE_CYCLES);
  localparam logic [3:0] STABLE_C = 4'(STABLE_FRAMES);

  // Returns {error, nibble}; the all-off pattern is handled by the caller.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h70:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
`ifdef LED_SCAN_DECODER_ALT_GLYPHS_EN
      7'h1F:   r = 5'h06;
      7'h72:   r = 5'h07;
      7'h73:   r = 5'h09;
`endif
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  // Returns {exactly_one_hot, index_of_highest_set_bit}.
  function automatic logic [3:0] onehot_pos(input logic [5:0] m);
    logic [2:0] ones;
    logic [2:0] pos;
    ones = 3'd0;
    pos  = 3'd0;
    for (int i = 0; i < 6; i++) begin
      ones = ones + {2'b00, m[i]};
      if (m[i]) begin
        pos = 3'(i);
      end else begin
        pos = pos;
      end
    end
    return {(ones == 3'd1), pos};
  endfunction

  logic [7:0]  seg_r;        // dp forced to 0 so it never counts as a change
  logic [5:0]  mask_r;
  logic [7:0]  settle_r;
  logic        cap_r;
  logic [23:0] buf_r;
  logic [5:0]  seen_r;
  logic [5:0]  dark_r;       // captured positions whose glyph was all-off
  logic        err_r;
  logic [3:0]  frame_cnt_r;

  logic        in_change_s;
  logic [3:0]  hot_s;
  logic [4:0]  dec_s;
  logic        is_blank_s;
  logic [3:0]  cap_nib_s;
  logic        cap_err_s;
  logic [5:0]  pos_bit_s;
  logic        repeat_s;
  logic [23:0] ins_buf_s;
  logic [23:0] seed_buf_s;
  logic [23:0] commit_bcd_s;
  logic [5:0]  commit_blank_s;
  logic [3:0]  next_cnt_s;

  // Change detect, decode of the held digit and next-frame-buffer images
  always_comb begin
    in_change_s = ((display_led_segments & 8'hFE) != seg_r) ||
                  (display_led_enable_mask != mask_r);
    hot_s      = onehot_pos(mask_r);
    dec_s      = decode_glyph(seg_r[7:1]);
    is_blank_s = (seg_r == 8'h00);
    pos_bit_s  = 6'b000001 << hot_s[2:0];
    if (is_blank_s) begin
      cap_nib_s = 4'h0;
    end else begin
      cap_nib_s = dec_s[3:0];
    end
    // A multi-hot mask is an error; a legal mask errs only on a bad glyph.
    if (!hot_s[3]) begin
      cap_err_s = 1'b1;
    end else if (is_blank_s) begin
      cap_err_s = 1'b0;
    end else begin
      cap_err_s = dec_s[4];
    end
    repeat_s = hot_s[3] && ((seen_r & pos_bit_s) != 6'h00);
    for (int i = 0; i < 6; i++) begin
      ins_buf_s[4*i +: 4]    = pos_bit_s[i] ? cap_nib_s : buf_r[4*i +: 4];
      seed_buf_s[4*i +: 4]   = pos_bit_s[i] ? cap_nib_s : 4'h0;
      commit_bcd_s[4*i +: 4] = seen_r[i] ? buf_r[4*i +: 4] : 4'h0;
    end
    commit_blank_s = ~seen_r | dark_r;
    if (({commit_bcd_s, commit_blank_s} == {time_bcd, blank_mask}) && !err_r) begin
      if (frame_cnt_r == STABLE_C) begin
        next_cnt_s = frame_cnt_r;
      end else begin
        next_cnt_s = frame_cnt_r + 4'd1;
      end
    end else if (err_r) begin
      next_cnt_s = 4'd0;
    end else begin
      next_cnt_s = 4'd1;
    end
  end

  // Input qualifier: one capture pulse per settled dwell, re-armed by change
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r    <= 8'h00;
      mask_r   <= 6'h00;
      settle_r <= 8'h00;
      cap_r    <= 1'b0;
    end else begin
      seg_r  <= display_led_segments & 8'hFE;
      mask_r <= display_led_enable_mask;
      // The cycle that registers a new value is the first cycle of its dwell.
      if (in_change_s) begin
        settle_r <= 8'd1;
        cap_r    <= (SETTLE_C == 8'd1);
      end else if (settle_r != SETTLE_C) begin
        settle_r <= settle_r + 8'd1;
        cap_r    <= ((settle_r + 8'd1) == SETTLE_C);
      end else begin
        cap_r <= 1'b0;
      end
    end
  end

  // Frame assembly, commit on repeated position, stability tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_r        <= 24'h000000;
      seen_r       <= 6'h00;
      dark_r       <= 6'h00;
      err_r        <= 1'b0;
      frame_cnt_r  <= 4'd0;
      time_bcd     <= 24'h000000;
      blank_mask   <= 6'h3F;
      frame_strobe <= 1'b0;
      glyph_error  <= 1'b0;
      stable       <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      glyph_error  <= 1'b0;
      if (cap_r && (mask_r != 6'h00)) begin
        if (repeat_s) begin
          time_bcd     <= commit_bcd_s;
          blank_mask   <= commit_blank_s;
          frame_strobe <= 1'b1;
          glyph_error  <= err_r;
          frame_cnt_r  <= next_cnt_s;
          stable       <= (next_cnt_s == STABLE_C);
          // The triggering capture, and its error, open the new frame.
          buf_r        <= seed_buf_s;
          seen_r       <= pos_bit_s;
          dark_r       <= is_blank_s ? pos_bit_s : 6'h00;
          err_r        <= cap_err_s;
        end else if (hot_s[3]) begin
          buf_r  <= ins_buf_s;
          seen_r <= seen_r | pos_bit_s;
          dark_r <= dark_r | (is_blank_s ? pos_bit_s : 6'h00);
          err_r  <= err_r | cap_err_s;
        end else begin
          err_r <= 1'b1;
        end
      end
    end
  end

endmodule
